// File: rtl/control_banda.sv
// Pipeline sequencer: per-stage load enables and valid bits, consumer back-pressure,
// flush and drain handling, plus a saturating completed-result counter.
module control_banda #(
  parameter int STAGES = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              clear_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  input  logic              flush_i,
  input  logic              drain_i,
  output logic [STAGES-1:0] stage_load_o,
  output logic [STAGES-1:0] stage_valid_o,
  output logic              busy_o,
  output logic              drain_done_o,
  output logic [CNT_W-1:0]  done_count_o,
  output logic              count_sat_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state_q;
  logic [STAGES-1:0]   stageValid_q;
  logic [STAGES-1:0]   stageValid_d;
  logic [STAGES-1:0]   move;
  logic [STAGES-1:0]   upstream;
  logic                drainDone_q;
  logic [CNT_W-1:0]    doneCount_q;
  logic [CNT_W-1:0]    doneCount_d;
  logic                countSat_q;
  logic                accept;
  logic                handshake;

  // A stage may advance when it is empty or everything below it advances,
  // so bubbles collapse even while the consumer stalls.
  always_comb begin
    move     = '0;
    upstream = '0;
    move[STAGES-1] = ~stageValid_q[STAGES-1] | out_ready_i;
    for (int i = STAGES - 2; i >= 0; i--) begin
      move[i] = ~stageValid_q[i] | move[i+1];
    end
    in_ready_o  = clear_i & move[0] & ~flush_i & (state_q != DRAIN) & ~drain_i;
    accept      = in_valid_i & in_ready_o;
    upstream[0] = accept;
    for (int i = 1; i < STAGES; i++) begin
      upstream[i] = stageValid_q[i-1];
    end
    stage_load_o = (clear_i && !flush_i) ? (move & upstream) : '0;
    stageValid_d = flush_i ? '0 : ((move & upstream) | (~move & stageValid_q));
    handshake    = stageValid_q[STAGES-1] & out_ready_i;
    doneCount_d  = (handshake && !(&doneCount_q)) ? doneCount_q + 1'b1 : doneCount_q;
  end

  always_ff @(posedge clk_i) begin
    if (!clear_i) begin
      state_q      <= IDLE;
      stageValid_q <= '0;
      drainDone_q  <= 1'b0;
      doneCount_q  <= '0;
      countSat_q   <= 1'b0;
    end else begin
      stageValid_q <= stageValid_d;
      doneCount_q  <= doneCount_d;
      countSat_q   <= countSat_q | (&doneCount_d);
      drainDone_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (drain_i) begin
            drainDone_q <= 1'b1;
          end else if (accept) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (!flush_i && drain_i) begin
            state_q <= DRAIN;
          end else if (stageValid_d == '0 && !accept) begin
            state_q <= IDLE;
          end
        end
        DRAIN: begin
          // A flush also terminates the drain, so the pulse still fires.
          if (flush_i || stageValid_d == '0) begin
            state_q     <= IDLE;
            drainDone_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid_o   = stageValid_q[STAGES-1];
  assign stage_valid_o = stageValid_q;
  assign busy_o        = (state_q != IDLE);
  assign drain_done_o  = drainDone_q;
  assign done_count_o  = doneCount_q;
  assign count_sat_o   = countSat_q;

endmodule

// File: tb/tb_control_banda.sv
// Bench for control_banda: a shadow datapath clocked by stage_load feeds a scoreboard,
// with directed checks for reset, streaming, stall, flush, drain and saturation.
module tb_control_banda;

  localparam int S = 3;

  logic clk = 1'b0;
  logic clear, inValid, outReady, flush, drain;
  logic inReady, outValid, busy, drainDone, countSat;
  logic [S-1:0] stageLoad, stageValid;
  logic [7:0] doneCount;
  logic inReady3, outValid3, busy3, drainDone3, countSat3;
  logic [S-1:0] stageLoad3, stageValid3;
  logic [2:0] doneCount3;

  int checkCount = 0;
  int failCount  = 0;

  logic [7:0] shadow [S];
  logic [7:0] nextData = 8'd0;
  logic [7:0] sbQueue [$];
  int cnt8 = 0;
  int cnt3 = 0;
  logic sat3 = 1'b0;

  always #5 clk = ~clk;

  control_banda #(.STAGES(S), .CNT_W(8)) dut (
    .clk_i(clk), .clear_i(clear), .in_valid_i(inValid), .in_ready_o(inReady),
    .out_valid_o(outValid), .out_ready_i(outReady), .flush_i(flush), .drain_i(drain),
    .stage_load_o(stageLoad), .stage_valid_o(stageValid), .busy_o(busy),
    .drain_done_o(drainDone), .done_count_o(doneCount), .count_sat_o(countSat)
  );

  control_banda #(.STAGES(S), .CNT_W(3)) dut3 (
    .clk_i(clk), .clear_i(clear), .in_valid_i(inValid), .in_ready_o(inReady3),
    .out_valid_o(outValid3), .out_ready_i(outReady), .flush_i(flush), .drain_i(drain),
    .stage_load_o(stageLoad3), .stage_valid_o(stageValid3), .busy_o(busy3),
    .drain_done_o(drainDone3), .done_count_o(doneCount3), .count_sat_o(countSat3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic clr, input logic iv, input logic ordy,
                               input logic fl, input logic dr);
    @(negedge clk);
    clear    = clr;
    inValid  = iv;
    outReady = ordy;
    flush    = fl;
    drain    = dr;
    #1;
  endtask

  // Scoreboard and shadow datapath, sampled just before each rising edge.
  always @(negedge clk) begin
    #4;
    if (!clear) begin
      sbQueue.delete();
      cnt8 = 0;
      cnt3 = 0;
      sat3 = 1'b0;
    end else begin
      if (outValid && outReady) begin
        if (sbQueue.size() == 0) begin
          checkOutput("sbUnderflow", 32'd0, 32'd1);
        end else begin
          checkOutput("sbData", {24'd0, shadow[S-1]}, {24'd0, sbQueue.pop_front()});
        end
        if (cnt8 != 255) cnt8++;
        if (cnt3 != 7) cnt3++;
        if (cnt3 == 7) sat3 = 1'b1;
      end
      if (flush) sbQueue.delete();
      if (inValid && inReady) sbQueue.push_back(nextData);
      for (int i = S - 1; i >= 1; i--) begin
        if (stageLoad[i]) shadow[i] = shadow[i-1];
      end
      if (stageLoad[0]) shadow[0] = nextData;
      if (inValid && inReady) nextData = nextData + 8'd1;
    end
  end

  initial begin
    clear = 1'b0; inValid = 1'b1; outReady = 1'b0; flush = 1'b0; drain = 1'b0;

    $display("[TB] reset");
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("rstInReady", inReady, 0);
    checkOutput("rstStageLoad", stageLoad, 0);
    checkOutput("rstStageValid", stageValid, 0);
    checkOutput("rstDoneCount", doneCount, 0);
    checkOutput("rstBusy", busy, 0);

    $display("[TB] streaming");
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1, k < 5, 1, 0, 0);
      checkOutput("strOutValid", outValid, (k >= 3 && k <= 7));
      if (k == 0) checkOutput("strInReady", inReady, 1);
      if (k == 1) checkOutput("strBusy", busy, 1);
    end
    checkOutput("strDoneCount", doneCount, 5);
    checkOutput("strIdle", busy, 0);

    $display("[TB] back-pressure");
    repeat (3) applyStimulus(1, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 1, 0, 0, 0);
      checkOutput("bpInReady", inReady, 0);
      checkOutput("bpStageLoad", stageLoad, 0);
      checkOutput("bpStageValid", stageValid, 3'b111);
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 0, 1, 0, 0);
      checkOutput("bpOutValid", outValid, k < 3);
    end
    checkOutput("bpEmpty", stageValid, 0);
    checkOutput("bpDoneCount", doneCount, 8);

    $display("[TB] flush");
    repeat (3) applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 1, 0);
    checkOutput("flInReady", inReady, 0);
    checkOutput("flStageLoad", stageLoad, 0);
    checkOutput("flOutValid", outValid, 1);
    applyStimulus(1, 0, 1, 0, 0);
    checkOutput("flStageValid", stageValid, 0);
    checkOutput("flOutValidAfter", outValid, 0);
    checkOutput("flInReadyAfter", inReady, 1);
    checkOutput("flDoneCount", doneCount, 9);

    $display("[TB] drain");
    repeat (2) applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 1);
    checkOutput("drStageValid", stageValid, 3'b011);
    checkOutput("drInReady", inReady, 0);
    checkOutput("drBusy", busy, 1);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1, 1, 1, 0, 0);
      checkOutput("drOutValid", outValid, 1);
      checkOutput("drInReadyHeld", inReady, 0);
      checkOutput("drDoneEarly", drainDone, 0);
    end
    applyStimulus(1, 0, 1, 0, 0);
    checkOutput("drDonePulse", drainDone, 1);
    checkOutput("drBusyOff", busy, 0);
    checkOutput("drOutValidOff", outValid, 0);
    applyStimulus(1, 0, 1, 0, 0);
    checkOutput("drDoneOnce", drainDone, 0);
    checkOutput("drDoneCount", doneCount, 11);

    $display("[TB] drain while idle");
    applyStimulus(1, 0, 1, 0, 1);
    checkOutput("idDrainInReady", inReady, 0);
    applyStimulus(1, 0, 1, 0, 0);
    checkOutput("idDrainPulse", drainDone, 1);
    checkOutput("idDrainBusy", busy, 0);
    applyStimulus(1, 0, 1, 0, 0);
    checkOutput("idDrainOnce", drainDone, 0);

    $display("[TB] saturation");
    checkOutput("satPreCount", doneCount3, 7);
    checkOutput("satPreSticky", countSat3, 1);
    applyStimulus(0, 0, 0, 0, 0);
    for (int k = 0; k < 13; k++) begin
      applyStimulus(1, k < 9, 1, 0, 0);
      checkOutput("satCount", doneCount3, cnt3);
      checkOutput("satFlag", countSat3, sat3);
      checkOutput("satCount8", doneCount, cnt8);
    end
    checkOutput("satFinalCount", doneCount3, 7);
    checkOutput("satFinalFlag", countSat3, 1);
    checkOutput("satWideCount", doneCount, 9);
    checkOutput("satWideFlag", countSat, 0);
    checkOutput("sbLeftover", sbQueue.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
